// File: rtl/ysyx_23060221_axi_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : ysyx_23060221_axi_master                                 |
// | Brief   : Core request/response port to AXI4 initiator, one        |
// |           transaction in flight (INCR read bursts, 1-beat writes). |
// |           Optional macro: YSYX_23060221_AXI_LANE_SEL_EN            |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module ysyx_23060221_axi_master #(
    parameter logic [3:0] AXI_ID = 4'd0,
    parameter int         ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    // core side
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,
    input  logic [7:0]        req_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_last,
    output logic              rsp_err,
    // AXI write address
    output logic              awvalid,
    input  logic              awready,
    output logic [ADDR_W-1:0] awaddr,
    output logic [3:0]        awid,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    // AXI write data
    output logic              wvalid,
    input  logic              wready,
    output logic [63:0]       wdata,
    output logic [7:0]        wstrb,
    output logic              wlast,
    // AXI write response
    input  logic              bvalid,
    output logic              bready,
    input  logic [1:0]        bresp,
    input  logic [3:0]        bid,
    // AXI read address
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    output logic [3:0]        arid,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    // AXI read data
    input  logic              rvalid,
    output logic              rready,
    input  logic [1:0]        rresp,
    input  logic [63:0]       rdata,
    input  logic              rlast,
    input  logic [3:0]        rid
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_WR   = 3'd3,
        S_B    = 3'd4
    } state_t;

    localparam logic [2:0] c_SIZE_4B    = 3'b010;
    localparam logic [1:0] c_BURST_INCR = 2'b01;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic [7:0]        r_len;
    logic [7:0]        r_cnt;
    logic              r_extra;
    logic              r_aw_done;
    logic              r_w_done;

    logic              w_req_hs;
    logic              w_ar_hs;
    logic              w_r_hs;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_b_hs;
    logic              w_len_bad;
    logic [31:0]       w_rd_lane;
    logic [63:0]       w_wdata64;
    logic [7:0]        w_wstrb8;
    logic              w_unused;

    assign w_req_hs = req_valid & req_ready;
    assign w_ar_hs  = arvalid & arready;
    assign w_r_hs   = rvalid & rready;
    assign w_aw_hs  = awvalid & awready;
    assign w_w_hs   = wvalid & wready;
    assign w_b_hs   = bvalid & bready;

    // rlast on the wrong beat: either early, or after beats past len were taken
    assign w_len_bad = (r_cnt != r_len) | r_extra;

`ifdef YSYX_23060221_AXI_LANE_SEL_EN
    logic r_lane;

    assign w_rd_lane = r_lane ? rdata[63:32] : rdata[31:0];
    assign w_wdata64 = {r_wdata, r_wdata};
    assign w_wstrb8  = r_addr[2] ? {r_wstrb, 4'b0000} : {4'b0000, r_wstrb};
    assign w_unused  = ^{bid, rid, rresp[0], bresp[0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lane <= 1'b0;
        end else if (w_req_hs) begin
            r_lane <= req_addr[2];
        end else if (w_r_hs) begin
            r_lane <= ~r_lane;
        end
    end
`else
    assign w_rd_lane = rdata[31:0];
    assign w_wdata64 = {32'b0, r_wdata};
    assign w_wstrb8  = {4'b0000, r_wstrb};
    assign w_unused  = ^{bid, rid, rresp[0], bresp[0], rdata[63:32]};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_wdata   <= 32'b0;
            r_wstrb   <= 4'b0;
            r_len     <= 8'b0;
            r_cnt     <= 8'b0;
            r_extra   <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_req_hs) begin
                r_addr    <= req_addr;
                r_wdata   <= req_wdata;
                r_wstrb   <= req_wstrb;
                r_len     <= req_len;
                r_cnt     <= 8'b0;
                r_extra   <= 1'b0;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (w_r_hs) begin
                if (r_cnt != 8'hFF) begin
                    r_cnt <= r_cnt + 8'd1;
                end
                if ((r_cnt == r_len) && !rlast) begin
                    r_extra <= 1'b1;
                end
            end
            if (w_aw_hs) begin
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                r_w_done <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_req_hs) w_next = req_wen ? S_WR : S_AR;
            S_AR:   if (w_ar_hs) w_next = S_R;
            S_R:    if (w_r_hs && rlast) w_next = S_IDLE;
            S_WR:   if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) w_next = S_B;
            S_B:    if (w_b_hs) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Every handshake signal is forced low while reset is held, whatever the state
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = 32'b0;
        rsp_last  = 1'b0;
        rsp_err   = 1'b0;
        awvalid   = 1'b0;
        awaddr    = '0;
        awid      = 4'b0;
        awlen     = 8'b0;
        awsize    = 3'b0;
        awburst   = 2'b0;
        wvalid    = 1'b0;
        wdata     = 64'b0;
        wstrb     = 8'b0;
        wlast     = 1'b0;
        bready    = 1'b0;
        arvalid   = 1'b0;
        araddr    = '0;
        arid      = 4'b0;
        arlen     = 8'b0;
        arsize    = 3'b0;
        arburst   = 2'b0;
        rready    = 1'b0;
        if (!reset) begin
            case (r_state)
                S_IDLE: begin
                    req_ready = 1'b1;
                end
                S_AR: begin
                    arvalid = 1'b1;
                    araddr  = r_addr;
                    arid    = AXI_ID;
                    arlen   = r_len;
                    arsize  = c_SIZE_4B;
                    arburst = c_BURST_INCR;
                end
                S_R: begin
                    rready    = rsp_ready;
                    rsp_valid = rvalid;
                    rsp_rdata = w_rd_lane;
                    rsp_last  = rlast;
                    rsp_err   = rresp[1] | (rlast & w_len_bad);
                end
                S_WR: begin
                    awvalid = ~r_aw_done;
                    awaddr  = r_addr;
                    awid    = AXI_ID;
                    awlen   = 8'b0;
                    awsize  = c_SIZE_4B;
                    awburst = c_BURST_INCR;
                    wvalid  = ~r_w_done;
                    wdata   = w_wdata64;
                    wstrb   = w_wstrb8;
                    wlast   = 1'b1;
                end
                S_B: begin
                    bready    = rsp_ready;
                    rsp_valid = bvalid;
                    rsp_last  = 1'b1;
                    rsp_err   = bresp[1];
                end
                default: begin
                    req_ready = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060221_axi_master.sv
`default_nettype none
// Randomized self-checking bench for ysyx_23060221_axi_master; the bench acts as
// both core and AXI responder and predicts every response from transaction rules.
module tb_ysyx_23060221_axi_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_wen;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic [7:0]  req_len;
    logic        rsp_valid, rsp_ready, rsp_last, rsp_err;
    logic [31:0] rsp_rdata;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [31:0] awaddr, araddr;
    logic [3:0]  awid, bid, arid, rid;
    logic [7:0]  awlen, arlen, wstrb;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [63:0] wdata, rdata;
    logic        arvalid, arready, rvalid, rready, rlast;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ysyx_23060221_axi_master dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_last(rsp_last), .rsp_err(rsp_err),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rresp(rresp), .rdata(rdata),
        .rlast(rlast), .rid(rid)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait for acceptance, then scramble the request bus
    task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] st, input logic [7:0] len);
        int n;
        n = 0;
        req_valid = 1'b1; req_wen = wen; req_addr = addr;
        req_wdata = wd; req_wstrb = st; req_len = len;
        #1;
        while (req_ready !== 1'b1 && n < 20) begin
            step;
            n++;
        end
        n_vec++;
        if (req_ready !== 1'b1 || arvalid !== 1'b0 || awvalid !== 1'b0) begin
            n_err++;
            $display("FAIL issue: req_ready=%b arvalid=%b awvalid=%b, want 1 0 0",
                     req_ready, arvalid, awvalid);
        end
        step;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        req_wstrb = 4'($urandom); req_len = 8'($urandom); req_wen = 1'($urandom);
    endtask

    // mode 0: always ready; 1: fixed rsp_ready pattern; 2: random rvalid/rsp_ready
    task automatic run_read(input logic [31:0] addr, input int len, input int last_idx,
                            input int err_beat, input int mode, input int rv_delay);
        int beat, cyc, ar_wait;
        bit done, exp_err;
        logic [31:0] exp;
        int pat[6] = '{1, 0, 1, 1, 0, 1};
        issue(1'b0, addr, 32'h0, 4'h0, len[7:0]);
        ar_wait = (mode == 2) ? $urandom_range(0, 2) : 0;
        for (int i = 0; i <= ar_wait; i++) begin
            arready = (i == ar_wait);
            #1;
            n_vec++;
            if (arvalid !== 1'b1 || araddr !== addr || arlen !== len[7:0] || arsize !== 3'd2 ||
                arburst !== 2'd1 || arid !== 4'd0) begin
                n_err++;
                $display("FAIL ar_chan: arvalid=%b araddr=%h arlen=%0d arsize=%0d arburst=%0d arid=%0d, want 1 %h %0d 2 1 0",
                         arvalid, araddr, arlen, arsize, arburst, arid, addr, len);
            end
            step;
        end
        arready = 1'b0;
        beat = 0; done = 0; cyc = 0;
        while (!done && cyc < 2000) begin
            if (cyc < rv_delay) rvalid = 1'b0;
            else rvalid = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            rsp_ready = (mode == 1) ? 1'(pat[cyc % 6]) : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            rdata = {$urandom, $urandom};
            rlast = (beat == last_idx);
            rresp = (beat == err_beat) ? 2'b10 : 2'b00;
            rid = 4'($urandom);
            #1;
`ifdef YSYX_23060221_AXI_LANE_SEL_EN
            exp = (addr[2] ^ beat[0]) ? rdata[63:32] : rdata[31:0];
`else
            exp = rdata[31:0];
`endif
            exp_err = rresp[1] | (rlast && beat != len);
            n_vec++;
            if (rready !== rsp_ready || rsp_valid !== rvalid || arvalid !== 1'b0) begin
                n_err++;
                $display("FAIL r_handshake: rready=%b rsp_valid=%b arvalid=%b, want %b %b 0",
                         rready, rsp_valid, arvalid, rsp_ready, rvalid);
            end
            if (rvalid) begin
                n_vec++;
                if (rsp_rdata !== exp || rsp_last !== rlast || rsp_err !== exp_err) begin
                    n_err++;
                    $display("FAIL r_beat%0d: rdata=%h last=%b err=%b, want %h %b %b",
                             beat, rsp_rdata, rsp_last, rsp_err, exp, rlast, exp_err);
                end
            end
            if (rvalid && rsp_ready) begin
                if (rlast) done = 1;
                beat++;
            end
            step;
            cyc++;
        end
        rvalid = 1'b0; rlast = 1'b0; rsp_ready = 1'b0;
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL r_timeout: beats=%0d, want rlast at beat %0d", beat, last_idx);
        end
        #1;
        n_vec++;
        if (req_ready !== 1'b1 || rready !== 1'b0) begin
            n_err++;
            $display("FAIL r_done: req_ready=%b rready=%b, want 1 0", req_ready, rready);
        end
    endtask

    task automatic run_write(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] st,
                             input int awd, input int wdl, input int bd, input logic [1:0] br);
        int last;
        logic [63:0] ewd;
        logic [7:0]  ews;
        last = (awd > wdl) ? awd : wdl;
`ifdef YSYX_23060221_AXI_LANE_SEL_EN
        ewd = {wd, wd};
        ews = addr[2] ? {st, 4'b0} : {4'b0, st};
`else
        ewd = {32'b0, wd};
        ews = {4'b0, st};
`endif
        issue(1'b1, addr, wd, st, 8'($urandom));
        for (int c = 0; c <= last; c++) begin
            awready = (c == awd); wready = (c == wdl);
            rsp_ready = 1'($urandom_range(0, 1)); bvalid = 1'b0;
            #1;
            n_vec++;
            if (awvalid !== (c <= awd) || wvalid !== (c <= wdl) || arvalid !== 1'b0 ||
                rsp_valid !== 1'b0 || bready !== 1'b0) begin
                n_err++;
                $display("FAIL wr_valids c%0d: awvalid=%b wvalid=%b arvalid=%b rsp_valid=%b bready=%b, want %b %b 0 0 0",
                         c, awvalid, wvalid, arvalid, rsp_valid, bready, c <= awd, c <= wdl);
            end
            if (awvalid === 1'b1) begin
                n_vec++;
                if (awaddr !== addr || awlen !== 8'd0 || awsize !== 3'd2 || awburst !== 2'd1 || awid !== 4'd0) begin
                    n_err++;
                    $display("FAIL aw_chan: awaddr=%h awlen=%0d awsize=%0d awburst=%0d awid=%0d, want %h 0 2 1 0",
                             awaddr, awlen, awsize, awburst, awid, addr);
                end
            end
            if (wvalid === 1'b1) begin
                n_vec++;
                if (wdata !== ewd || wstrb !== ews || wlast !== 1'b1) begin
                    n_err++;
                    $display("FAIL w_chan: wdata=%h wstrb=%h wlast=%b, want %h %h 1",
                             wdata, wstrb, wlast, ewd, ews);
                end
            end
            step;
        end
        awready = 1'b0; wready = 1'b0;
        for (int c = 0; c <= bd; c++) begin
            bvalid = (c == bd) ? 1'b1 : 1'($urandom_range(0, 1));
            rsp_ready = (c == bd);
            bresp = (c == bd) ? br : 2'($urandom);
            bid = 4'($urandom);
            #1;
            n_vec++;
            if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== rsp_ready || rsp_valid !== bvalid ||
                rsp_last !== 1'b1 || rsp_rdata !== 32'h0 || (bvalid && rsp_err !== bresp[1])) begin
                n_err++;
                $display("FAIL b_chan: awv=%b wv=%b bready=%b rsp_valid=%b last=%b rdata=%h err=%b, want 0 0 %b %b 1 0 %b",
                         awvalid, wvalid, bready, rsp_valid, rsp_last, rsp_rdata, rsp_err,
                         rsp_ready, bvalid, bresp[1]);
            end
            step;
        end
        bvalid = 1'b0; rsp_ready = 1'b0;
        #1;
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL w_done: req_ready=%b, want 1", req_ready);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step;
        step;
        rsp_ready = 1'b1; rvalid = 1'b1; bvalid = 1'b1;
        #1;
        n_vec++;
        if (req_ready !== 1'b0 || arvalid !== 1'b0 || awvalid !== 1'b0 || wvalid !== 1'b0 ||
            rready !== 1'b0 || bready !== 1'b0 || rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: req_ready=%b arv=%b awv=%b wv=%b rready=%b bready=%b rsp_valid=%b, want all 0",
                     req_ready, arvalid, awvalid, wvalid, rready, bready, rsp_valid);
        end
        rsp_ready = 1'b0; rvalid = 1'b0; bvalid = 1'b0;
        reset = 1'b0;
        #1;
        n_vec++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: req_ready=%b rsp_valid=%b, want 1 0", req_ready, rsp_valid);
        end
        step;
    endtask

    task automatic test_single_read;
        run_read(32'h8000_0010, 0, 0, -1, 0, 2);
    endtask

    task automatic test_split_write;
        run_write(32'h8000_0004, 32'h1234_5678, 4'hF, 1, 3, 1, 2'b00);
        run_write(32'h8000_0008, 32'hCAFE_F00D, 4'h3, 2, 0, 0, 2'b00);
        run_write(32'h8000_000C, 32'h0BAD_0BAD, 4'h6, 0, 0, 2, 2'b00);
    endtask

    task automatic test_burst_backpressure;
        run_read(32'h8000_0100, 3, 3, -1, 1, 0);
    endtask

    task automatic test_errors;
        run_write(32'h8000_0020, 32'h5555_AAAA, 4'hC, 0, 0, 0, 2'b10);
        run_read(32'h8000_0200, 3, 2, -1, 0, 0);
        run_read(32'h8000_0300, 1, 3, -1, 0, 0);
        run_read(32'h8000_0404, 2, 2, 1, 0, 0);
    endtask

    task automatic test_reset_mid_burst;
        issue(1'b0, 32'h8000_0040, 32'h0, 4'h0, 8'd3);
        arready = 1'b1;
        step;
        arready = 1'b0;
        rvalid = 1'b1; rsp_ready = 1'b1; rlast = 1'b0; rresp = 2'b00; rdata = {$urandom, $urandom};
        step;
        reset = 1'b1;
        #1;
        n_vec++;
        if (rready !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_hold: rready=%b rsp_valid=%b req_ready=%b, want 0 0 0",
                     rready, rsp_valid, req_ready);
        end
        step;
        n_vec++;
        if (rready !== 1'b0 || arvalid !== 1'b0 || awvalid !== 1'b0 || req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_edge: rready=%b arvalid=%b awvalid=%b req_ready=%b, want 0 0 0 0",
                     rready, arvalid, awvalid, req_ready);
        end
        reset = 1'b0;
        rvalid = 1'b0; rsp_ready = 1'b0;
        #1;
        n_vec++;
        if (req_ready !== 1'b1 || rready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_release: req_ready=%b rready=%b, want 1 0", req_ready, rready);
        end
        step;
        run_read(32'h8000_0044, 1, 1, -1, 0, 0);
    endtask

    task automatic test_long_burst;
        run_read(32'h8000_1000, 255, 255, 100, 0, 0);
    endtask

    task automatic test_random;
        logic [31:0] a;
        int len, last, r;
        logic [1:0] br;
        for (int t = 0; t < 30; t++) begin
            a = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 1) == 1) begin
                r = $urandom_range(0, 3);
                br = (r == 0) ? 2'b10 : (r == 1) ? 2'b11 : (r == 2) ? 2'b01 : 2'b00;
                run_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3), br);
            end else begin
                len = $urandom_range(0, 7);
                r = $urandom_range(0, 5);
                last = (r == 0) ? len + 1 : (r == 1 && len > 0) ? len - 1 : len;
                run_read(a, len, last, $urandom_range(0, 12), 2, $urandom_range(0, 2));
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        req_wstrb = 4'h0; req_len = 8'h0; rsp_ready = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = 4'h0;
        arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = 64'h0; rlast = 1'b0; rid = 4'h0;
        test_reset;
        test_single_read;
        test_split_write;
        test_burst_backpressure;
        test_errors;
        test_reset_mid_burst;
        test_long_burst;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx_23060221_axi_master.md
Name: ysyx_23060221_axi_master

Overview:
AXI4 initiator that converts the core's simple request/response port (IFU/LSU side) into AXI4 transactions toward the data-memory responder.
- Reads: one AR, then an INCR burst of 1..256 beats.
- Writes: single beat only; AW and W issued concurrently, then one B is collected.
- One outstanding transaction at a time; sits between the core and the memory/crossbar.

Parameters:
AXI_ID, 0, value driven on awid/arid; returned bid/rid are not checked.
ADDR_W, 32, address width.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  1  core request valid
req_ready  out  1  core request accepted (IDLE only)
req_wen  in  1  1=write, 0=read
req_addr  in  ADDR_W  byte address
req_wdata  in  32  write data
req_wstrb  in  4  write byte strobes
req_len  in  8  read beats minus 1 (ignored for writes)
rsp_valid  out  1  response beat valid
rsp_ready  in  1  core accepts response beat
rsp_rdata  out  32  read data
rsp_last  out  1  final beat of the transaction
rsp_err  out  1  resp[1] of the beat (SLVERR/DECERR)
awvalid out 1; awready in 1; awaddr out 32; awid out 4; awlen out 8; awsize out 3; awburst out 2
wvalid out 1; wready in 1; wdata out 64; wstrb out 8; wlast out 1
bvalid in 1; bready out 1; bresp in 2; bid in 4
arvalid out 1; arready in 1; araddr out 32; arid out 4; arlen out 8; arsize out 3; arburst out 2
rvalid in 1; rready out 1; rresp in 2; rdata in 64; rlast in 1; rid in 4

Behaviour:
- One clock domain; reset is synchronous, active-high.
- FSM states: IDLE, AR, R, WR, B.
- While reset is asserted:
  - state <= IDLE; arvalid, awvalid, wvalid, rready, bready, rsp_valid are all 0.
  - req_ready = 0 (req_ready = state==IDLE & ~reset).
- Reset mid-transaction: abandon the transaction, return to IDLE on that edge, drop all valids. No completion is attempted; the responder is reset together with this block.
- IDLE: on req_valid & req_ready, latch addr, wdata, wstrb, len, wen.
  - wen=0 -> AR.
  - wen=1 -> WR.
  - Latency: valid request edge to arvalid/awvalid high = 1 cycle (registered).
- AR: arvalid=1 with araddr, arlen=len, arsize=3'b010, arburst=2'b01 (INCR), arid=AXI_ID. All fields are stable until arvalid & arready. On handshake -> R.
- R:
  - rready = rsp_ready.
  - rsp_valid = rvalid, rsp_rdata = selected lane, rsp_last = rlast, rsp_err = rresp[1]. All combinational pass-through, zero added latency.
  - Beat counter (8-bit) increments on each rvalid & rready.
  - On the handshake with rlast=1 -> IDLE.
  - If rlast arrives with counter != len, still finish and force rsp_err=1 on that beat.
  - If the counter reaches len without rlast, keep accepting beats until rlast. Counter saturates at 255.
- WR:
  - awvalid=1 and wvalid=1 together. awlen=0, awsize=3'b010, awburst=2'b01, wlast=1.
  - Each valid drops independently the cycle after its own handshake; simultaneous handshakes are allowed.
  - awready may precede wready or vice versa.
  - -> B once both handshakes are done (same cycle as the later handshake).
- B:
  - bready = rsp_ready; rsp_valid = bvalid, rsp_last=1, rsp_err = bresp[1], rsp_rdata = 0.
  - On bvalid & bready -> IDLE.
- Back-to-back: req_ready is high the cycle after the final R/B handshake, so there is one idle cycle minimum between transactions.
- Outputs not listed for a state are 0.

Optional Feature:
Macro YSYX_23060221_AXI_LANE_SEL_EN.
- Defined: 64-bit lane steering by latched addr[2].
  - wdata = {wdata32, wdata32}; wstrb = addr[2] ? {strb,4'b0} : {4'b0,strb}.
  - rsp_rdata = addr[2] ? rdata[63:32] : rdata[31:0].
  - For bursts, the lane toggles per beat starting from addr[2].
- Undefined: wdata = {32'b0, wdata32}, wstrb = {4'b0, strb}, rsp_rdata = rdata[31:0] always. This matches a responder that returns 32-bit data in the low lane.

Test Plan:
- Single read: req addr=0x80000010, len=0; arready high immediately, rvalid 2 cycles later with rdata low=0xDEADBEEF, rlast=1 -> arvalid high 1 cycle after accept; one rsp beat 0xDEADBEEF, rsp_last=1, rsp_err=0; req_ready back high next cycle.
- Write with split handshakes: addr=0x80000004, wdata=0x12345678, wstrb=0xF; awready at cycle 1, wready at cycle 3 -> awvalid drops after cycle 1, wvalid held to cycle 3; wlast=1; bresp=0 -> one rsp with rsp_last=1, rsp_err=0.
- Burst read with backpressure: len=3; rsp_ready toggles 1,0,1,1,0,1 -> rready mirrors rsp_ready; exactly 4 beats delivered; rsp_last only on the 4th beat.
- Error: bresp=2'b10 -> rsp_err=1. Read burst len=3 with rlast on beat 2 -> rsp_err=1 on that beat, FSM returns to IDLE.
- Reset mid-burst: assert reset in R after 1 beat -> next edge rready=0, arvalid=0, req_ready=0 during reset, then 1 after release; a new read completes normally.
- Lane select (macro on): read addr=0x...4, rdata=0xAAAA_BBBB_CCCC_DDDD -> rsp_rdata=0xAAAABBBB. Write addr[2]=1, strb=0x3 -> wstrb=0x30.
